// File: rtl/sdm_alloc_req_ctl.sv
// sdm_alloc_req_ctl: per-input request FSMs feeding the SDM M-N match allocator.
module sdm_alloc_req_ctl #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   hd_vld,
  input  logic [N*M-1:0] hd_dst,
  output logic [N-1:0]   hd_rdy,
  input  logic [N-1:0]   tl_vld,
  output logic [N*M-1:0] r,
  input  logic [M*N-1:0] cfg,
  output logic [N*M-1:0] gnt,
  output logic [N-1:0]   busy,
  output logic [N-1:0]   err
);
  typedef enum logic [1:0] {IDLE, REQ, ACTIVE, REL} state_t;
  logic [M*N-1:0] cfg_meta_q, cfg_s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_meta_q <= '0;
      cfg_s      <= '0;
    end else begin
      cfg_meta_q <= cfg;
      cfg_s      <= cfg_meta_q;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_in
    state_t         state_q, state_d;
    logic [M-1:0]   r_q, r_d, gnt_q, gnt_d, dst, col, hit, sel;
    logic           rdy_q, rdy_d, err_q, err_d;
    always_comb begin
      dst = hd_dst[i*M +: M];
      for (int k = 0; k < M; k++) col[k] = cfg_s[k*N+i];
      hit = col & r_q;
      sel = '0;
      // descending scan so the lowest granted resource wins
      for (int k = M-1; k >= 0; k--) if (hit[k]) begin
        sel = '0;
        sel[k] = 1'b1;
      end
      state_d = state_q;
      r_d     = r_q;
      gnt_d   = gnt_q;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
        IDLE:   if (hd_vld[i]) begin
          if (|dst) begin
            r_d     = dst;
            state_d = REQ;
          end else err_d = 1'b1;
        end
        REQ:    if (|hit) begin
          r_d     = sel;
          gnt_d   = sel;
          rdy_d   = 1'b1;
          state_d = ACTIVE;
        end
        ACTIVE: if (tl_vld[i]) begin
          r_d     = '0;
          state_d = REL;
        end
        REL:    if (~|col) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        r_q     <= '0;
        gnt_q   <= '0;
        rdy_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        r_q     <= r_d;
        gnt_q   <= gnt_d;
        rdy_q   <= rdy_d;
        err_q   <= err_d;
      end
    end
    assign r[i*M +: M]   = r_q;
    assign gnt[i*M +: M] = gnt_q;
    assign hd_rdy[i]     = rdy_q;
    assign err[i]        = err_q;
    assign busy[i]       = state_q != IDLE;
  end
endmodule

// File: tb/tb_sdm_alloc_req_ctl.sv
// tb_sdm_alloc_req_ctl: directed stimulus with a queue scoreboard for hd_rdy/err events.
module tb_sdm_alloc_req_ctl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] hd_vld = '0, tl_vld = '0, hd_rdy, busy, err;
  logic [3:0] hd_dst = '0, r, cfg = '0, gnt;
  int total = 0, bad = 0;
  logic [2:0] q0[$], q1[$];
  sdm_alloc_req_ctl dut (
    .clk(clk), .rst_n(rst_n), .hd_vld(hd_vld), .hd_dst(hd_dst), .hd_rdy(hd_rdy),
    .tl_vld(tl_vld), .r(r), .cfg(cfg), .gnt(gnt), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // monitor: each hd_rdy/err pulse pops {err, gnt} expected for that input
  always @(negedge clk) begin
    logic [2:0] e;
    if (hd_rdy[0] | err[0]) begin
      if (q0.size() == 0) chk("unexpected_evt0", {29'd0, err[0], gnt[1:0]}, 32'hFFFF_FFFF);
      else begin
        e = q0.pop_front();
        chk("evt0", {29'd0, err[0], gnt[1:0]}, {29'd0, e});
      end
    end
    if (hd_rdy[1] | err[1]) begin
      if (q1.size() == 0) chk("unexpected_evt1", {29'd0, err[1], gnt[3:2]}, 32'hFFFF_FFFF);
      else begin
        e = q1.pop_front();
        chk("evt1", {29'd0, err[1], gnt[3:2]}, {29'd0, e});
      end
    end
  end
  initial begin
    cyc(2);
    chk("rst_r", r, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {hd_rdy, err}, 0);
    rst_n = 1'b1;
    cyc(1);
    // single frame on input 0, grant resource 1
    hd_vld = 2'b01; hd_dst = 4'b0011;
    cyc(1);
    hd_vld = 2'b00;
    chk("f1_r", r, 4'b0011);
    chk("f1_busy", busy, 2'b01);
    q0.push_back(3'b010);
    cfg = 4'b0100;
    cyc(2);
    chk("f1_not_yet", gnt, 0);
    cyc(1);
    chk("f1_gnt", gnt, 4'b0010);
    chk("f1_r1hot", r, 4'b0010);
    tl_vld = 2'b01;
    cyc(1);
    tl_vld = 2'b00;
    chk("f1_tail_r", r, 0);
    chk("f1_rel_gnt", gnt, 4'b0010);
    chk("f1_rel_busy", busy, 2'b01);
    cfg = 4'b0000;
    cyc(3);
    chk("f1_idle_busy", busy, 0);
    chk("f1_idle_gnt", gnt, 0);
    // request hold on input 1 with head toggling
    hd_vld = 2'b10; hd_dst = 4'b0100;
    cyc(1);
    for (int c = 0; c < 50; c++) begin
      hd_vld = {c[0], 1'b0}; hd_dst = 4'b1100;
      cyc(1);
      chk("hold_r", r, 4'b0100);
    end
    hd_vld = 2'b00;
    q1.push_back(3'b001);
    cfg = 4'b0010;
    cyc(3);
    chk("hold_gnt", gnt, 4'b0100);
    tl_vld = 2'b10;
    cyc(1);
    tl_vld = 2'b00; cfg = 4'b0000;
    cyc(3);
    chk("hold_done", busy, 0);
    // multi-bit grant picks lowest resource
    hd_vld = 2'b01; hd_dst = 4'b0011;
    cyc(1);
    hd_vld = 2'b00;
    q0.push_back(3'b001);
    cfg = 4'b0101;
    cyc(3);
    chk("multi_gnt", gnt, 4'b0001);
    chk("multi_r", r, 4'b0001);
    tl_vld = 2'b01;
    cyc(1);
    tl_vld = 2'b00; cfg = 4'b0000;
    cyc(3);
    chk("multi_done", busy, 0);
    // zero destination
    q1.push_back(3'b100);
    hd_vld = 2'b10; hd_dst = 4'b0000;
    cyc(1);
    hd_vld = 2'b00;
    chk("zero_r", r, 0);
    chk("zero_busy", busy, 0);
    chk("zero_err", err, 2'b10);
    cyc(1);
    chk("zero_err_off", err, 0);
    // contention on resource 0, input 1 wins first
    hd_vld = 2'b11; hd_dst = 4'b0101;
    cyc(1);
    hd_vld = 2'b00;
    chk("cont_r", r, 4'b0101);
    q1.push_back(3'b001);
    cfg = 4'b0010;
    cyc(3);
    chk("cont_busy", busy, 2'b11);
    chk("cont_gnt1", gnt, 4'b0100);
    cyc(5);
    chk("cont_r0_held", r, 4'b0101);
    tl_vld = 2'b10;
    cyc(1);
    tl_vld = 2'b00; cfg = 4'b0000;
    cyc(3);
    chk("cont_rel1", busy, 2'b01);
    q0.push_back(3'b001);
    cfg = 4'b0001;
    cyc(3);
    chk("cont_gnt0", gnt, 4'b0001);
    chk("cont_r0", r, 4'b0001);
    // asynchronous reset while input 0 is ACTIVE
    #2 rst_n = 1'b0;
    #1;
    chk("arst_r", r, 0);
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    cfg = 4'b0000;
    cyc(1);
    rst_n = 1'b1;
    hd_vld = 2'b01; hd_dst = 4'b0001;
    cyc(1);
    hd_vld = 2'b00;
    chk("post_rst_r", r, 4'b0001);
    chk("post_rst_busy", busy, 2'b01);
    q0.push_back(3'b001);
    cfg = 4'b0001;
    cyc(3);
    chk("post_rst_gnt", gnt, 4'b0001);
    tl_vld = 2'b01;
    cyc(1);
    tl_vld = 2'b00; cfg = 4'b0000;
    cyc(4);
    chk("end_busy", busy, 0);
    chk("q_drained", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
